// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the memory request controller: state encoding,
// default timeout and the read data returned when an access times out.
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int DEF_TIMEOUT   = 16;
  localparam int TIMEOUT_RDATA = 0;

  // A request is pending whenever the CPU asserts either access strobe.
  function automatic logic reqActive(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_timeout_counter.sv
// Up-counter that bounds the time spent waiting for a memory acknowledge.
// termCount flags the last permitted REQ cycle (count == TIMEOUT-1).
module mem_req_ctrl_timeout_counter
  import mem_req_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic termCount
);

  logic [CNT_W-1:0] count;

  // Count REQ cycles; cleared on entry so each access gets a full budget.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign termCount = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side memory request controller between the MEM stage and a
// multi-cycle data memory. Holds one request stable until ack or timeout,
// stalls the pipeline meanwhile, returns load data and flags timeouts.
//
// state | meaning
// IDLE  | waiting for cpu_read_i/cpu_write_i; stall follows the request
// REQ   | request presented to memory, waiting for mem_ack_i or timeout
// DONE  | one-cycle release; pipeline advances, read data valid
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  stateT             state;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              writeQ;
  logic [DATA_W-1:0] rdataQ;
  logic              errQ;
  logic              req;
  logic              startReq;
  logic              timeoutHit;

  assign req      = reqActive(cpu_read_i, cpu_write_i);
  assign startReq = (state == IDLE) && req;

  mem_req_ctrl_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) uTimeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear     (startReq),
    .enable    (state == REQ),
    .termCount (timeoutHit)
  );

  // Request sequencing: latch on acceptance, complete on ack or timeout.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      addrQ  <= '0;
      wdataQ <= '0;
      writeQ <= 1'b0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addrQ  <= cpu_addr_i;
            wdataQ <= cpu_wdata_i;
            writeQ <= cpu_write_i;
            state  <= REQ;
          end
        end
        REQ: begin
          // Ack beats a coincident timeout; stores keep the old read data.
          if (mem_ack_i) begin
            if (!writeQ) begin
              rdataQ <= mem_rdata_i;
            end
            state <= DONE;
          end else if (timeoutHit) begin
            errQ   <= 1'b1;
            rdataQ <= DATA_W'(TIMEOUT_RDATA);
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall is gated by reset so the pipeline is released the moment reset asserts.
  assign cpu_stall_o  = rst_i & (startReq | (state == REQ));
  assign mem_enable_o = (state == REQ);
  assign mem_write_o  = writeQ;
  assign mem_addr_o   = addrQ;
  assign mem_wdata_o  = wdataQ;
  assign cpu_rdata_o  = rdataQ;
  assign err_o        = errQ;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: the stimulus process pushes expected
// per-access results from a transaction-level model; a monitor compares.
module tb_mem_req_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cpu_read_i = 1'b0;
  logic          cpu_write_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;
  logic          mem_enable_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_read_i   (cpu_read_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .err_o        (err_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          err;
    int            stallCyc;
    int            enCyc;
  } expT;

  expT           sb[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] modelRdata = '0;
  logic          modelErr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle memory-port stability and per-access completion.
  initial begin
    int  stallCnt;
    int  enCnt;
    bit  prevStall;
    expT e;
    stallCnt = 0; enCnt = 0; prevStall = 1'b0;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        check("rst_enable", mem_enable_o, 0);
        check("rst_stall", cpu_stall_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", cpu_rdata_o, 0);
        sb.delete();
        stallCnt = 0; enCnt = 0; prevStall = 1'b0;
      end else begin
        if (mem_enable_o) begin
          enCnt++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL enable_without_request actual=1 required=0 @%0t", $time);
          end else begin
            check("mem_addr", mem_addr_o, sb[0].addr);
            check("mem_write", mem_write_o, sb[0].wr);
            check("mem_wdata", mem_wdata_o, sb[0].wdata);
          end
        end
        if (cpu_stall_o) begin
          stallCnt++;
        end else if (prevStall) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL release_without_request actual=1 required=0 @%0t", $time);
          end else begin
            e = sb.pop_front();
            check("done_rdata", cpu_rdata_o, e.rdata);
            check("done_err", err_o, e.err);
            check("stall_cycles", stallCnt, e.stallCyc);
            check("enable_cycles", enCnt, e.enCyc);
          end
          stallCnt = 0; enCnt = 0;
        end
        prevStall = cpu_stall_o;
      end
    end
  end

  // One CPU access; n = REQ edge carrying the ack, n > TO means no ack at all.
  task automatic doTxn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int n,
                       input logic [DW-1:0] rdata, input bit lateAck);
    expT e;
    bit  timedOut;
    timedOut = (n > TO);
    if (timedOut) begin
      modelRdata = '0;
      modelErr   = 1'b1;
    end else if (!wr) begin
      modelRdata = rdata;
    end
    e.addr = addr; e.wdata = wdata; e.wr = wr;
    e.rdata = modelRdata; e.err = modelErr;
    e.stallCyc = timedOut ? TO + 1 : n + 1;
    e.enCyc    = timedOut ? TO : n;
    sb.push_back(e);
    @(negedge clk_i);
    cpu_read_i = rd; cpu_write_i = wr; cpu_addr_i = addr; cpu_wdata_i = wdata;
    @(posedge clk_i);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk_i);
      cpu_addr_i  = $urandom;
      cpu_wdata_i = $urandom;
      mem_ack_i   = (k == n);
      mem_rdata_i = (k == n) ? rdata : DW'($urandom);
      @(posedge clk_i);
      if (k == n) break;
    end
    @(negedge clk_i);
    cpu_read_i = 1'b0; cpu_write_i = 1'b0;
    mem_ack_i   = lateAck;
    mem_rdata_i = $urandom;
    @(posedge clk_i);
    if (lateAck) begin
      #2;
      check("late_ack_rdata", cpu_rdata_o, modelRdata);
      check("late_ack_enable", mem_enable_o, 0);
      check("late_ack_stall", cpu_stall_o, 0);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask

  task automatic strayAck();
    @(negedge clk_i);
    mem_ack_i   = 1'b1;
    mem_rdata_i = $urandom;
    @(posedge clk_i);
    #2;
    check("stray_ack_enable", mem_enable_o, 0);
    check("stray_ack_stall", cpu_stall_o, 0);
    check("stray_ack_rdata", cpu_rdata_o, modelRdata);
    check("stray_ack_err", err_o, modelErr);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask

  task automatic resetMidReq();
    expT e;
    e.addr = 32'h77; e.wdata = 32'h55; e.wr = 1'b0;
    e.rdata = '0; e.err = 1'b0; e.stallCyc = 0; e.enCyc = 0;
    sb.push_back(e);
    @(negedge clk_i);
    cpu_read_i = 1'b1; cpu_addr_i = 32'h77; cpu_wdata_i = 32'h55;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("reset_async_enable", mem_enable_o, 0);
    check("reset_async_stall", cpu_stall_o, 0);
    modelRdata = '0;
    modelErr   = 1'b0;
    @(negedge clk_i);
    cpu_read_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int  kind;
    int  n;
    bit  rd;
    bit  wr;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("post_reset_addr", mem_addr_o, 0);
    check("post_reset_stall", cpu_stall_o, 0);

    doTxn(1'b1, 1'b0, 32'd3, 32'h0, 1, 32'h0000_00AA, 1'b0);
    doTxn(1'b0, 1'b1, 32'd5, 32'h1234, 4, 32'hDEAD_BEEF, 1'b0);
    doTxn(1'b1, 1'b1, 32'd2, 32'h9999, 2, 32'h1111_2222, 1'b0);
    strayAck();
    doTxn(1'b1, 1'b0, 32'd8, 32'h0, TO, 32'h0BAD_F00D, 1'b1);
    doTxn(1'b1, 1'b0, 32'd9, 32'h0, TO + 1, 32'h0, 1'b0);
    doTxn(1'b1, 1'b0, 32'd10, 32'h0, 3, 32'hCAFE_0001, 1'b1);
    doTxn(1'b0, 1'b1, 32'd11, 32'h4321, 1, 32'h0, 1'b0);
    strayAck();
    resetMidReq();
    doTxn(1'b1, 1'b0, 32'd12, 32'h0, 2, 32'h0000_5A5A, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      n = $urandom_range(1, TO + 2);
      doTxn(rd, wr, AW'($urandom), DW'($urandom), n, DW'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) strayAck();
    end

    doTxn(1'b1, 1'b0, 32'd13, 32'h0, TO + 2, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelRdata = '0;
    modelErr   = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("err_cleared_by_reset", err_o, 0);
    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
